// File: rtl/mat_pkg.sv
// Shared definitions for the matrix operand stream blocks: FSM states,
// default geometry and the row-major element index helper.
package mat_pkg;

  localparam int unsigned MAT_N_DEF  = 2;
  localparam int unsigned MAT_DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_DONE
  } mat_state_e;

  function automatic int unsigned idx(input int unsigned r,
                                      input int unsigned c,
                                      input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Nested i/j/k loop counter (k innermost). Exposes current and next values
// plus wrap flags so both stream ends can share the same iteration order.
module mat_idx_counter
  import mat_pkg::*;
#(
  parameter int unsigned N = MAT_N_DEF,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] i_o,
  output logic [CW-1:0] j_o,
  output logic [CW-1:0] k_o,
  output logic [CW-1:0] i_nxt_o,
  output logic [CW-1:0] j_nxt_o,
  output logic [CW-1:0] k_nxt_o,
  output logic          k_wrap_o,
  output logic          j_wrap_o,
  output logic          all_wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] i_q, j_q, k_q;
  logic [CW-1:0] i_d, j_d, k_d;

  assign i_o = i_q;
  assign j_o = j_q;
  assign k_o = k_q;

  assign k_wrap_o   = (k_q == LAST);
  assign j_wrap_o   = k_wrap_o && (j_q == LAST);
  assign all_wrap_o = j_wrap_o && (i_q == LAST);

  // Wrap explicitly at N-1 so non-power-of-two N never visits illegal indices.
  always_comb begin
    k_nxt_o = k_wrap_o ? '0 : k_q + CW'(1);
    j_nxt_o = j_q;
    i_nxt_o = i_q;
    if (k_wrap_o) begin
      j_nxt_o = (j_q == LAST) ? '0 : j_q + CW'(1);
    end
    if (j_wrap_o) begin
      i_nxt_o = (i_q == LAST) ? '0 : i_q + CW'(1);
    end
  end

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (en_i) begin
      i_d = i_nxt_o;
      j_d = j_nxt_o;
      k_d = k_nxt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/mat_stream_tx.sv
// Operand stream transmitter: holds A and B, and on start emits the 8-bit
// AXI-Stream A[i][k], B[k][j] in dot-product order for every (i, j, k).
module mat_stream_tx
  import mat_pkg::*;
#(
  parameter int unsigned N  = MAT_N_DEF,
  parameter int unsigned DW = MAT_DW_DEF,
  parameter int unsigned AW = $clog2(N * N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_e,
  input  logic          i_wr_en,
  input  logic          i_wr_sel,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] m_axis_data,
  output logic          m_axis_valid,
  input  logic          m_axis_ready,
  output logic          m_axis_last
);

  localparam int unsigned DEPTH = N * N;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(N);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  mat_state_e    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  logic          wr_ok;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] a_rd_idx, b_rd_idx;
  logic [DW-1:0] a_rd, b_rd;
  logic          xfer;

  logic          cnt_clr, cnt_en;
  logic [CW-1:0] cnt_i, cnt_j, cnt_k;
  logic [CW-1:0] cnt_i_nxt, cnt_j_nxt, cnt_k_nxt;
  logic          k_wrap, j_wrap, all_wrap;

  mat_idx_counter #(.N(N)) u_cnt (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .i_o        (cnt_i),
    .j_o        (cnt_j),
    .k_o        (cnt_k),
    .i_nxt_o    (cnt_i_nxt),
    .j_nxt_o    (cnt_j_nxt),
    .k_nxt_o    (cnt_k_nxt),
    .k_wrap_o   (k_wrap),
    .j_wrap_o   (j_wrap),
    .all_wrap_o (all_wrap)
  );

  assign wr_ok  = i_clk_e && i_wr_en && (state_q == ST_IDLE) && ({1'b0, i_wr_addr} < DEPTH_W);
  assign wr_idx = i_wr_addr[IW-1:0];

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      if (i_wr_sel) begin
        mem_b[wr_idx] <= i_wr_data;
      end else begin
        mem_a[wr_idx] <= i_wr_data;
      end
    end
  end

  assign a_rd_idx = (state_q == ST_IDLE) ? '0
                  : IW'(idx(32'(cnt_i_nxt), 32'(cnt_k_nxt), N));
  assign b_rd_idx = IW'(idx(32'(cnt_k), 32'(cnt_j), N));

  // A write landing on the same edge as start must appear in the first beat.
  assign a_rd = (wr_ok && !i_wr_sel && (wr_idx == a_rd_idx)) ? i_wr_data : mem_a[a_rd_idx];
  assign b_rd = mem_b[b_rd_idx];

  assign xfer = i_clk_e && valid_q && m_axis_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (i_clk_e) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_SEND_A;
            data_d  = a_rd;
            valid_d = 1'b1;
            last_d  = 1'b0;
            cnt_clr = 1'b1;
          end
        end
        ST_SEND_A: begin
          if (xfer) begin
            state_d = ST_SEND_B;
            data_d  = b_rd;
            last_d  = all_wrap;
          end
        end
        ST_SEND_B: begin
          if (xfer) begin
            cnt_en = 1'b1;
            last_d = 1'b0;
            if (all_wrap) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
            end else begin
              state_d = ST_SEND_A;
              data_d  = a_rd;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign m_axis_data  = data_q;
  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;
  assign o_busy       = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
  assign o_done       = (state_q == ST_DONE) && i_clk_e;

endmodule
